// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and constants for the LED strip path.
//   color_t       24-bit pixel word, GRB byte order (G[23:16] R[15:8] B[7:0])
//   COLOR_ADDR_W  palette address width
//   seq_state_t   frame sequencer states
//   COLOR_*       palette contents, shared by color_memory and its users
//   next_index()  palette index advance with wrap
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int COLOR_ADDR_W = 3;

    typedef logic [23:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_LATCH,
        ST_HOLD
    } seq_state_t;

    // GRB order: 24'hGG_RR_BB
    localparam color_t COLOR_WHITE  = 24'hFF_FF_FF;
    localparam color_t COLOR_BLUE   = 24'h00_00_FF;
    localparam color_t COLOR_OFF    = 24'h00_00_00;
    localparam color_t COLOR_GREEN  = 24'hFF_00_00;
    localparam color_t COLOR_YELLOW = 24'hFF_FF_00;

    function automatic logic [COLOR_ADDR_W-1:0] next_index(
        input logic [COLOR_ADDR_W-1:0] idx,
        input int                      num_colors
    );
        if (int'(idx) == num_colors - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

endpackage

// File: rtl/color_memory.sv
// ---------------------------------------------------------------------------
// color_memory
// Combinational palette ROM feeding the frame sequencer.
//   addr  in   COLOR_ADDR_W  palette address
//   data  out  color_t       palette word (combinational from addr)
// Unpopulated addresses read as off.
// ---------------------------------------------------------------------------
module color_memory
    import led_pkg::*;
(
    input  logic [COLOR_ADDR_W-1:0] addr,
    output color_t                  data
);

    always_comb begin
        data = COLOR_OFF;
        case (addr)
            3'd0:    data = COLOR_WHITE;
            3'd1:    data = COLOR_BLUE;
            3'd2:    data = COLOR_OFF;
            3'd3:    data = COLOR_GREEN;
            3'd4:    data = COLOR_YELLOW;
            default: data = COLOR_OFF;
        endcase
    end

endmodule

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
// Loadable down-counter. Loading N-1 makes done rise after N-1 further
// cycles, so a state that loads on entry sees done in its N-th cycle.
//   clk       in   1  clock
//   rst_n     in   1  asynchronous active-low reset
//   load      in   1  reload request (takes priority over counting)
//   load_val  in   W  value to load
//   count     out  W  remaining count
//   done      out  1  count has reached zero
// ---------------------------------------------------------------------------
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    assign done = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (!done)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/color_sequencer.sv
// ---------------------------------------------------------------------------
// color_sequencer
// Walks the palette in order, streaming one colour word per LED to the bit
// serializer, then holds the latch gap and a dwell before the next colour.
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   enable      in   1   run request, sampled in IDLE and at end of HOLD
//   mem_addr    out  3   palette address (registered; this is the index)
//   mem_data    in   24  palette word for mem_addr
//   pix_valid   out  1   pixel word available
//   pix_ready   in   1   serializer accepts word
//   pix_data    out  24  pixel word, constant for the whole frame
//   frame_done  out  1   pulse in the last latch-gap cycle
//   busy        out  1   high outside IDLE
// ---------------------------------------------------------------------------
module color_sequencer
    import led_pkg::*;
#(
    parameter int NUM_COLORS   = 5,
    parameter int NUM_LEDS     = 8,
    parameter int LATCH_CYCLES = 4000,
    parameter int HOLD_CYCLES  = 50_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    output logic [COLOR_ADDR_W-1:0] mem_addr,
    input  color_t                  mem_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output color_t                  pix_data,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int TMR_MAX = (LATCH_CYCLES > HOLD_CYCLES) ? LATCH_CYCLES : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PIX_W   = $clog2(NUM_LEDS + 1);

    localparam logic [TMR_W-1:0] LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_LEDS - 1);

    seq_state_t       state;
    logic [PIX_W-1:0] pix_cnt;
    logic             xfer;
    logic             last_xfer;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic [TMR_W-1:0] tmr_count;
    logic             tmr_done;

    assign xfer      = pix_valid & pix_ready;
    assign last_xfer = (state == ST_SEND) && xfer && (pix_cnt == PIX_LAST);

    // The timer is reloaded on the same edge that enters LATCH or HOLD.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LATCH_LOAD;
        if (last_xfer) begin
            tmr_load = 1'b1;
            tmr_val  = LATCH_LOAD;
        end else if (state == ST_LATCH && tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
        end
    end

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_addr   <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    pix_data  <= mem_data;
                    pix_cnt   <= '0;
                    pix_valid <= 1'b1;
                    state     <= ST_SEND;
                end

                ST_SEND: begin
                    if (xfer) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (last_xfer) begin
                            pix_valid  <= 1'b0;
                            state      <= ST_LATCH;
                            // A one-cycle gap is its own final cycle.
                            frame_done <= (LATCH_CYCLES == 1);
                        end
                    end
                end

                ST_LATCH: begin
                    if (tmr_done)
                        state <= ST_HOLD;
                    else
                        // Registered pulse: raise it when the next cycle is the last.
                        frame_done <= (tmr_count == TMR_W'(1));
                end

                ST_HOLD: begin
                    if (tmr_done) begin
                        if (enable) begin
                            mem_addr <= next_index(mem_addr, NUM_COLORS);
                            state    <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// ---------------------------------------------------------------------------
// tb_color_sequencer
// Randomized bench for color_sequencer with the real palette attached.
// The reference is a frame-level model: palette table, wrap arithmetic and
// the expected SEND/LATCH/HOLD cycle counts derived from the ready pattern.
// ---------------------------------------------------------------------------
module tb_color_sequencer;

    localparam int NC = 5;
    localparam int NL = 3;
    localparam int LC = 4;
    localparam int HC = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        pix_ready;
    logic [2:0]  mem_addr;
    logic [23:0] mem_data;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] palette [NC] = '{24'hFFFFFF, 24'h0000FF, 24'h000000, 24'hFF0000, 24'hFFFF00};

    always #5 clk = ~clk;

    color_memory u_mem (
        .addr (mem_addr),
        .data (mem_data)
    );

    color_sequencer #(
        .NUM_COLORS   (NC),
        .NUM_LEDS     (NL),
        .LATCH_CYCLES (LC),
        .HOLD_CYCLES  (HC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entry: at a negedge, with the DUT just moved into LOAD for palette idx.
    // Exit: at the negedge after the edge that leaves HOLD.
    // mode 0: ready always high; 1: pattern 1,0,0,1,0,1; 2: random.
    task automatic do_frame(input int idx, input int mode, input bit drop_en);
        bit rdy [64];
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        int xfers   = 0;
        int cyc     = 0;
        int exp_len = 0;
        int ones    = 0;
        bit v;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       rdy[i] = 1'b1;
                1:       rdy[i] = (i < 6) ? (pat[i] != 0) : 1'b1;
                default: rdy[i] = (i % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
        end
        for (int i = 0; i < 64; i++) begin
            if (rdy[i]) ones++;
            if (ones == NL && exp_len == 0) exp_len = i + 1;
        end

        chk("load_valid", pix_valid, 0);
        chk("load_busy", busy, 1);
        chk("load_addr", mem_addr, idx);
        pix_ready = 1'b1;   // ready while valid is low must not matter
        @(negedge clk);
        chk("send_valid", pix_valid, 1);
        chk("send_data", pix_data, palette[idx]);

        while (xfers < NL && cyc < 60) begin
            pix_ready = rdy[cyc];
            v = pix_valid;
            @(negedge clk);
            if (v && rdy[cyc]) xfers++;
            cyc++;
            if (drop_en && xfers >= 1) enable = 1'b0;
            if (xfers < NL) begin
                chk("send_hold_valid", pix_valid, 1);
                chk("send_hold_data", pix_data, palette[idx]);
            end else begin
                chk("send_end_valid", pix_valid, 0);
            end
        end
        if (xfers < NL) chk("send_timeout", xfers, NL);
        chk("send_len", cyc, exp_len);

        for (int c = 0; c < LC; c++) begin
            pix_ready = 1'($urandom_range(0, 1));
            chk("latch_frame_done", frame_done, (c == LC - 1) ? 1 : 0);
            chk("latch_busy", busy, 1);
            chk("latch_valid", pix_valid, 0);
            @(negedge clk);
        end
        for (int c = 0; c < HC; c++) begin
            pix_ready = 1'($urandom_range(0, 1));
            chk("hold_frame_done", frame_done, 0);
            chk("hold_busy", busy, 1);
            chk("hold_addr", mem_addr, idx);
            @(negedge clk);
        end

        if (enable) begin
            chk("next_busy", busy, 1);
            chk("next_addr", mem_addr, (idx + 1) % NC);
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_addr", mem_addr, idx);
            chk("idle_valid", pix_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst_n     = 1'b1;
        enable    = 1'b0;
        pix_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_enable", busy, 0);

        // Basic frame and palette wrap: colours 0,1,2,3,4,0
        enable = 1'b1;
        @(negedge clk);
        do_frame(0, 0, 1'b0);
        do_frame(1, 0, 1'b0);
        do_frame(2, 2, 1'b0);
        do_frame(3, 2, 1'b0);
        do_frame(4, 2, 1'b0);
        do_frame(0, 0, 1'b0);

        // Backpressure
        do_frame(1, 1, 1'b0);

        // Enable dropped after first transfer: frame completes, then IDLE
        do_frame(2, 0, 1'b1);
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_stay_busy", busy, 0);
        chk("idle_stay_addr", mem_addr, 2);
        chk("idle_stay_valid", pix_valid, 0);

        // Resume, then reset asynchronously in the middle of LATCH
        enable = 1'b1;
        @(negedge clk);
        do_frame(2, 2, 1'b0);
        pix_ready = 1'b1;
        @(negedge clk);
        k = 0;
        while (pix_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_latch", k, NL);
        chk("pre_rst_addr", mem_addr, 3);
        chk("pre_rst_data", pix_data, palette[3]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", mem_addr, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_data", pix_data, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
